// File: rtl/count_seq_ctrl_if.sv
// Host configuration channel for count_seq_ctrl: valid/ready handshake carrying
// the load value, terminal limit and one-shot/auto-reload mode.
interface count_seq_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_load;
   logic [WIDTH-1:0] cfg_limit;
   logic             cfg_mode;

   modport master (
      output cfg_valid, cfg_load, cfg_limit, cfg_mode,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_load, cfg_limit, cfg_mode,
      output cfg_ready
   );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencer for the up-counter datapath: config latch, run/pause, one-shot/auto-reload.
// Optional prescaler on the RUN advance is enabled by defining COUNT_PRESCALE_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | after reset, nothing programmed, config accepted
// S_LOADED | config latched, count = load, waiting for start
// S_RUN    | counting toward limit
// S_PAUSE  | stopped from RUN, count and prescaler phase held
// S_DONE   | one-shot reached limit, count held, config or restart accepted
module count_seq_ctrl #(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   count_seq_ctrl_if.slave    cfg,
   input  logic               start,
   input  logic               stop,
   output logic [WIDTH-1:0]   count,
   output logic               busy,
   output logic               done
`ifdef COUNT_PRESCALE_EN
   ,input logic [PRESC_W-1:0] presc_div
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOADED,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   load_r;
   logic [WIDTH-1:0]   limit_r;
   logic               mode_r;
   logic [PRESC_W-1:0] div_q;
   logic [PRESC_W-1:0] presc_lim;
   logic               cfg_acc;
   logic               presc_tick;

   // Without the prescaler the divider is tied to a zero limit, so it ticks every cycle.
`ifdef COUNT_PRESCALE_EN
   assign presc_lim = presc_div;
`else
   assign presc_lim = '0;
`endif

   assign cfg.cfg_ready = (state == S_IDLE) || (state == S_LOADED) || (state == S_DONE);
   assign cfg_acc       = cfg.cfg_valid && cfg.cfg_ready;
   assign presc_tick    = (div_q == presc_lim);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         load_r  <= '0;
         limit_r <= '0;
         mode_r  <= 1'b0;
         div_q   <= '0;
      end else begin
         done <= 1'b0;
         if (cfg_acc) begin
            load_r  <= cfg.cfg_load;
            limit_r <= cfg.cfg_limit;
            mode_r  <= cfg.cfg_mode;
            count   <= cfg.cfg_load;
            div_q   <= '0;
            state   <= S_LOADED;
            busy    <= 1'b0;
         end else begin
            case (state)
               S_LOADED: begin
                  if (start) begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                     div_q <= '0;
                  end
               end
               S_DONE: begin
                  if (start) begin
                     count <= load_r;
                     state <= S_RUN;
                     busy  <= 1'b1;
                     div_q <= '0;
                  end
               end
               S_RUN: begin
                  if (stop) begin
                     state <= S_PAUSE;
                     busy  <= 1'b0;
                  end else begin
                     div_q <= presc_tick ? '0 : div_q + 1'b1;
                     if (presc_tick) begin
                        if (count == limit_r) begin
                           done <= 1'b1;
                           if (mode_r) begin
                              count <= load_r;
                           end else begin
                              state <= S_DONE;
                              busy  <= 1'b0;
                           end
                        end else begin
                           count <= count + 1'b1;
                        end
                     end
                  end
               end
               S_PAUSE: begin
                  if (start && !stop) begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: per-cycle comparison against a behavioural
// model plus literal checks for each scenario.
module tb_count_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] presc_div = 4'd0;
   logic [7:0] count;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   count_seq_ctrl_if #(.WIDTH(8)) cif ();

   count_seq_ctrl #(.WIDTH(8), .PRESC_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .cfg   (cif.slave),
      .start (start),
      .stop  (stop),
      .count (count),
      .busy  (busy),
      .done  (done)
`ifdef COUNT_PRESCALE_EN
      ,.presc_div (presc_div)
`endif
   );

   always #5 clk = ~clk;

   localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

   int m_st, m_count, m_load, m_limit, m_mode, m_div;
   bit m_done;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cfg_set(input logic [7:0] ld, input logic [7:0] lim, input logic md);
      cif.cfg_valid = 1'b1;
      cif.cfg_load  = ld;
      cif.cfg_limit = lim;
      cif.cfg_mode  = md;
   endtask

   // Behavioural model: rules applied per clock edge with integer arithmetic.
   always @(posedge clk) begin
      if (reset) begin
         m_st = M_IDLE; m_count = 0; m_load = 0; m_limit = 0; m_mode = 0; m_div = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (cif.cfg_valid && (m_st == M_IDLE || m_st == M_LOADED || m_st == M_DONE)) begin
            m_load = int'(cif.cfg_load); m_limit = int'(cif.cfg_limit); m_mode = int'(cif.cfg_mode);
            m_count = m_load; m_div = 0; m_st = M_LOADED;
         end else if (m_st == M_LOADED && start) begin
            m_st = M_RUN; m_div = 0;
         end else if (m_st == M_DONE && start) begin
            m_st = M_RUN; m_div = 0; m_count = m_load;
         end else if (m_st == M_RUN && stop) begin
            m_st = M_PAUSE;
         end else if (m_st == M_RUN) begin
            if (m_div == int'(presc_div)) begin
               m_div = 0;
               if (m_count == m_limit) begin
                  m_done = 1;
                  if (m_mode != 0) m_count = m_load;
                  else m_st = M_DONE;
               end else begin
                  m_count = (m_count + 1) % 256;
               end
            end else begin
               m_div = m_div + 1;
            end
         end else if (m_st == M_PAUSE && start && !stop) begin
            m_st = M_RUN;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_count", {24'd0, count}, m_count);
         chk("cmp_busy", {31'd0, busy}, {31'd0, m_st == M_RUN});
         chk("cmp_done", {31'd0, done}, {31'd0, m_done});
         chk("cmp_ready", {31'd0, cif.cfg_ready},
             {31'd0, (m_st == M_IDLE || m_st == M_LOADED || m_st == M_DONE)});
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   int exp2_cnt [10] = '{5, 6, 7, 5, 6, 7, 5, 6, 7, 5};
   int exp2_done[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
   int exp3_cnt [5]  = '{'hFE, 'hFF, 'h00, 'h01, 'h01};
   int exp3_done[5]  = '{0, 0, 0, 0, 1};

   initial begin
      cif.cfg_valid = 1'b0; cif.cfg_load = '0; cif.cfg_limit = '0; cif.cfg_mode = 1'b0;
      reset = 1'b1;
      cyc(); cyc();
      chk_en = 1'b1;
      chk("rst_count", {24'd0, count}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_ready", {31'd0, cif.cfg_ready}, 1);
      reset = 1'b0;

      // one-shot 0x10..0x13
      cfg_set(8'h10, 8'h13, 1'b0); cyc(); cif.cfg_valid = 1'b0;
      chk("t1_loaded", {24'd0, count}, 'h10);
      start = 1'b1; cyc(); start = 1'b0;
      chk("t1_c0", {24'd0, count}, 'h10);
      chk("t1_busy", {31'd0, busy}, 1);
      cyc(); chk("t1_c1", {24'd0, count}, 'h11);
      cyc(); chk("t1_c2", {24'd0, count}, 'h12);
      cyc(); chk("t1_c3", {24'd0, count}, 'h13);
      chk("t1_nodone", {31'd0, done}, 0);
      cyc();
      chk("t1_done", {31'd0, done}, 1);
      chk("t1_hold", {24'd0, count}, 'h13);
      chk("t1_idle", {31'd0, busy}, 0);
      chk("t1_ready", {31'd0, cif.cfg_ready}, 1);
      cyc(); chk("t1_done_pulse", {31'd0, done}, 0);

      // auto-reload 5..7
      cfg_set(8'h05, 8'h07, 1'b1); cyc(); cif.cfg_valid = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) cyc();
         chk("t2_count", {24'd0, count}, exp2_cnt[k]);
         chk("t2_done", {31'd0, done}, exp2_done[k]);
      end
      stop = 1'b1; cyc(); stop = 1'b0;
      chk("t2_paused", {31'd0, busy}, 0);
      reset = 1'b1; cyc(); reset = 1'b0;

      // wrap through 0xFF
      cfg_set(8'hFE, 8'h01, 1'b0); cyc(); cif.cfg_valid = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) cyc();
         chk("t3_count", {24'd0, count}, exp3_cnt[k]);
         chk("t3_done", {31'd0, done}, exp3_done[k]);
      end

      // pause / resume
      cfg_set(8'h20, 8'hFF, 1'b0); cyc(); cif.cfg_valid = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      chk("t4_c0", {24'd0, count}, 'h20);
      for (int k = 0; k < 4; k++) cyc();
      chk("t4_c4", {24'd0, count}, 'h24);
      stop = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("t4_hold", {24'd0, count}, 'h24);
         chk("t4_busy", {31'd0, busy}, 0);
      end
      start = 1'b1; cyc();
      chk("t4_stopwins", {31'd0, busy}, 0);
      stop = 1'b0; cyc();
      chk("t4_resume_busy", {31'd0, busy}, 1);
      chk("t4_resume_cnt", {24'd0, count}, 'h24);
      start = 1'b0; cyc();
      chk("t4_c25", {24'd0, count}, 'h25);

      // reset mid-run, config ignored while running
      for (int k = 0; k < 40 && count != 8'h33; k++) cyc();
      chk("t5_reach33", {24'd0, count}, 'h33);
      reset = 1'b1; cyc();
      chk("t5_rst_count", {24'd0, count}, 0);
      chk("t5_rst_busy", {31'd0, busy}, 0);
      chk("t5_rst_done", {31'd0, done}, 0);
      chk("t5_rst_ready", {31'd0, cif.cfg_ready}, 1);
      reset = 1'b0;
      cfg_set(8'h40, 8'h50, 1'b0); cyc(); cif.cfg_valid = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      cfg_set(8'h99, 8'h99, 1'b1);
      chk("t5_ready_run", {31'd0, cif.cfg_ready}, 0);
      cyc(); cyc();
      chk("t5_count42", {24'd0, count}, 'h42);
      cif.cfg_valid = 1'b0;
      for (int k = 0; k < 40 && done !== 1'b1; k++) cyc();
      chk("t5_done_seen", {31'd0, done}, 1);
      chk("t5_limit_kept", {24'd0, count}, 'h50);
      start = 1'b1; cyc(); start = 1'b0;
      chk("t5_restart_cnt", {24'd0, count}, 'h40);
      chk("t5_restart_busy", {31'd0, busy}, 1);
      stop = 1'b1; cyc(); stop = 1'b0;
      reset = 1'b1; cyc(); reset = 1'b0;

      // limit == load auto-reload, config beats start
      cfg_set(8'h77, 8'h77, 1'b1); start = 1'b1; cyc(); cif.cfg_valid = 1'b0;
      chk("t7_cfgwins", {31'd0, busy}, 0);
      chk("t7_loaded", {24'd0, count}, 'h77);
      cyc();
      chk("t7_run", {31'd0, busy}, 1);
      chk("t7_nodone", {31'd0, done}, 0);
      start = 1'b0; cyc();
      chk("t7_done1", {31'd0, done}, 1);
      chk("t7_pinned", {24'd0, count}, 'h77);
      cyc();
      chk("t7_done2", {31'd0, done}, 1);
      stop = 1'b1; cyc(); stop = 1'b0;

`ifdef COUNT_PRESCALE_EN
      begin
         int first;
         reset = 1'b1; cyc(); reset = 1'b0;
         presc_div = 4'd2;
         cfg_set(8'h00, 8'h02, 1'b0); cyc(); cif.cfg_valid = 1'b0;
         start = 1'b1; cyc(); start = 1'b0;
         first = -1;
         for (int i = 1; i <= 12; i++) begin
            cyc();
            if (done === 1'b1 && first < 0) first = i;
         end
         chk("t6_done_lat", first, 9);
         chk("t6_count", {24'd0, count}, 2);
         start = 1'b1; cyc(); start = 1'b0;
         cyc();
         stop = 1'b1; cyc(); stop = 1'b0;
         start = 1'b1; cyc(); start = 1'b0;
         cyc();
         chk("t6_phase0", {24'd0, count}, 0);
         cyc();
         chk("t6_phase1", {24'd0, count}, 1);
         presc_div = 4'd0;
      end
`endif

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
